// File: rtl/bru_pkg.sv
// Shared types for the branch resolution unit: FSM states, default widths and
// the in-flight queue entry.
package bru_pkg;

  localparam int BRU_IDX_W = 5;
  localparam int BRU_PC_W  = 32;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic [BRU_IDX_W-1:0] idx;
    logic                 pred_taken;
    logic [BRU_PC_W-1:0]  target;
    logic [BRU_PC_W-1:0]  fallthru;
  } bru_entry_t;

endpackage

// File: rtl/bru_fifo.sv
// In-order circular queue of predicted branches. Pointers carry one extra
// wrap bit so full and empty are distinguishable; clear overrides push/pop.
module bru_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  bru_entry_t din,
  output logic       full,
  output logic       empty,
  output bru_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, rd_q;
  bru_entry_t  mem_q [DEPTH];

  logic do_push, do_pop;
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Payload storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Pops the oldest predicted branch on resolution, drives the BHT update port
// and the mispredict flush/redirect. Optional counters: BRU_PERF_CNT_EN.
module branch_resolution_unit
  import bru_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = BRU_IDX_W,
  parameter int PC_W  = BRU_PC_W
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             pred_valid,
  input  logic [IDX_W-1:0] pred_idx,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_target,
  input  logic [PC_W-1:0]  pred_fallthru,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             upd_en,
  output logic [IDX_W-1:0] upd_addr,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             q_empty,
  output logic             err_underflow,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispred
);

  bru_state_e state_q;
  logic       full, empty;
  bru_entry_t din, head;

  logic             upd_en_q, upd_taken_q, mispredict_q, err_q;
  logic [IDX_W-1:0] upd_addr_q;
  logic [PC_W-1:0]  redirect_q, redirect_d;

  logic run, push, pop, mismatch;

  assign run        = (state_q == RUN);
  assign pred_ready = !full && run;
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && !empty && run;
  assign mismatch   = pop && (res_taken != head.pred_taken);
  assign redirect_d = res_taken ? PC_W'(head.target) : PC_W'(head.fallthru);

  always_comb begin
    din            = '0;
    din.idx        = BRU_IDX_W'(pred_idx);
    din.pred_taken = pred_taken;
    din.target     = BRU_PC_W'(pred_target);
    din.fallthru   = BRU_PC_W'(pred_fallthru);
  end

  // A mismatching pop flushes every younger (wrong-path) entry, including
  // anything fetch pushes in the same cycle.
  bru_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (push),
    .pop    (pop),
    .clear  (mismatch),
    .din    (din),
    .full   (full),
    .empty  (empty),
    .head   (head)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= RUN;
      upd_en_q     <= 1'b0;
      upd_addr_q   <= '0;
      upd_taken_q  <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      upd_en_q     <= pop;
      mispredict_q <= mismatch;
      if (pop) begin
        upd_addr_q  <= IDX_W'(head.idx);
        upd_taken_q <= res_taken;
      end
      if (mismatch) redirect_q <= redirect_d;
      if (res_valid && empty && run) err_q <= 1'b1;
      case (state_q)
        RUN:     if (mismatch) state_q <= RECOVER;
        RECOVER: state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign upd_en        = upd_en_q;
  assign upd_addr      = upd_addr_q;
  assign upd_taken     = upd_taken_q;
  assign mispredict    = mispredict_q;
  assign redirect_pc   = redirect_q;
  assign q_empty       = empty;
  assign err_underflow = err_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_mp_q;

  // Saturating: a wrapped count would read as a tiny, misleading value.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (pop && perf_br_q != '1)      perf_br_q <= perf_br_q + 32'd1;
      if (mismatch && perf_mp_q != '1) perf_mp_q <= perf_mp_q + 32'd1;
    end
  end

  assign perf_branches = perf_br_q;
  assign perf_mispred  = perf_mp_q;
`else
  assign perf_branches = '0;
  assign perf_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit with hand-computed expectations.
module tb_branch_resolution_unit;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        pred_valid, pred_taken, res_valid, res_taken;
  logic [4:0]  pred_idx;
  logic [31:0] pred_target, pred_fallthru;
  logic        pred_ready, upd_en, upd_taken, mispredict, q_empty, err_underflow;
  logic [4:0]  upd_addr;
  logic [31:0] redirect_pc, perf_branches, perf_mispred;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_resolution_unit #(.DEPTH(4), .IDX_W(5), .PC_W(32)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .pred_valid    (pred_valid),
    .pred_idx      (pred_idx),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .pred_fallthru (pred_fallthru),
    .pred_ready    (pred_ready),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .upd_en        (upd_en),
    .upd_addr      (upd_addr),
    .upd_taken     (upd_taken),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
    .q_empty       (q_empty),
    .err_underflow (err_underflow),
    .perf_branches (perf_branches),
    .perf_mispred  (perf_mispred)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid = 0; res_valid = 0; res_taken = 0; pred_taken = 0;
    pred_idx = '0; pred_target = '0; pred_fallthru = '0;
  endtask

  task automatic set_pred(input logic [4:0] idx, input logic tk,
                          input logic [31:0] tgt, input logic [31:0] ft);
    pred_valid = 1; pred_idx = idx; pred_taken = tk;
    pred_target = tgt; pred_fallthru = ft;
  endtask

  task automatic push1(input logic [4:0] idx, input logic tk,
                       input logic [31:0] tgt, input logic [31:0] ft);
    set_pred(idx, tk, tgt, ft);
    step();
    pred_valid = 0;
  endtask

  task automatic resolve(input logic tk);
    res_valid = 1; res_taken = tk;
    step();
    res_valid = 0;
  endtask

  task automatic do_reset();
    arst_n = 0;
    #3;
    arst_n = 1;
    step();
  endtask

  initial begin
    int exp_br, exp_mp;
    idle();
    arst_n = 0;
    #12;
    chk("rst_upd_en", upd_en, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_q_empty", q_empty, 1);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_upd_addr", upd_addr, 0);
    chk("rst_perf_br", perf_branches, 0);
    arst_n = 1;
    step();
    chk("ready_after_rst", pred_ready, 1);

    // correct prediction
    push1(5'd3, 1, 32'h40, 32'h14);
    chk("t1_not_empty", q_empty, 0);
    resolve(1);
    chk("t1_upd_en", upd_en, 1);
    chk("t1_upd_addr", upd_addr, 3);
    chk("t1_upd_taken", upd_taken, 1);
    chk("t1_mispredict", mispredict, 0);
    chk("t1_empty", q_empty, 1);
    step();
    chk("t1_upd_en_pulse", upd_en, 0);

    // mispredict, then res_valid during RECOVER is ignored
    push1(5'd5, 0, 32'h80, 32'h24);
    resolve(1);
    chk("t2_mispredict", mispredict, 1);
    chk("t2_redirect", redirect_pc, 32'h80);
    chk("t2_upd_taken", upd_taken, 1);
    chk("t2_upd_addr", upd_addr, 5);
    chk("t2_ready_recover", pred_ready, 0);
    chk("t2_empty", q_empty, 1);
    resolve(1);
    chk("t2_recover_no_err", err_underflow, 0);
    chk("t2_mispredict_pulse", mispredict, 0);
    chk("t2_upd_en_ignored", upd_en, 0);
    chk("t2_redirect_hold", redirect_pc, 32'h80);
    chk("t2_ready_run", pred_ready, 1);

    // full queue rejects a push even alongside a pop
    for (int i = 1; i <= 4; i++) push1(5'(i), 0, 32'h100 + i, 32'h200 + i);
    chk("t3_full_ready", pred_ready, 0);
    set_pred(5'd9, 1, 32'h999, 32'h998);
    res_valid = 1; res_taken = 0;
    #1;
    chk("t3_full_ready_pop", pred_ready, 0);
    step();
    pred_valid = 0; res_valid = 0;
    chk("t3_pop_addr", upd_addr, 1);
    chk("t3_no_mispredict", mispredict, 0);
    chk("t3_ready_after", pred_ready, 1);
    for (int i = 2; i <= 4; i++) begin
      resolve(0);
      chk($sformatf("t3_drain_addr%0d", i), upd_addr, 5'(i));
    end
    chk("t3_empty_after3", q_empty, 1);

    // mismatch at head with concurrent push: everything flushed
    push1(5'd6, 1, 32'h300, 32'h304);
    push1(5'd7, 1, 32'h310, 32'h314);
    push1(5'd8, 1, 32'h320, 32'h324);
    set_pred(5'd10, 1, 32'h330, 32'h334);
    resolve(0);
    pred_valid = 0;
    chk("t4_mispredict", mispredict, 1);
    chk("t4_redirect", redirect_pc, 32'h304);
    chk("t4_upd_addr", upd_addr, 6);
    chk("t4_upd_taken", upd_taken, 0);
    chk("t4_empty", q_empty, 1);
    step();
    chk("t4_still_empty", q_empty, 1);
    resolve(1);
    chk("t4_underflow", err_underflow, 1);
    chk("t4_no_upd", upd_en, 0);

    // underflow is sticky until reset
    do_reset();
    chk("t5_err_cleared", err_underflow, 0);
    chk("t5_redirect_rst", redirect_pc, 0);
    resolve(0);
    chk("t5_underflow", err_underflow, 1);
    chk("t5_no_upd", upd_en, 0);
    step(); step();
    chk("t5_sticky", err_underflow, 1);
    do_reset();
    chk("t5_err_rst", err_underflow, 0);

    // reset mid-operation empties a non-empty queue
    push1(5'd11, 0, 32'h500, 32'h504);
    push1(5'd12, 0, 32'h510, 32'h514);
    arst_n = 0;
    #2;
    chk("t6_rst_empty", q_empty, 1);
    arst_n = 1;
    step();

    // 10 resolutions, mismatches on iterations 2, 5, 8
    for (int i = 0; i < 10; i++) begin
      bit mm;
      mm = (i == 2 || i == 5 || i == 8);
      push1(5'(i), 1, 32'h600 + i, 32'h700 + i);
      resolve(mm ? 1'b0 : 1'b1);
      if (mm) step();
    end
`ifdef BRU_PERF_CNT_EN
    exp_br = 10; exp_mp = 3;
`else
    exp_br = 0; exp_mp = 0;
`endif
    chk("perf_branches", perf_branches, 64'(exp_br));
    chk("perf_mispred", perf_mispred, 64'(exp_mp));
    chk("perf_last_redirect", redirect_pc, 32'h708);
    do_reset();
    chk("perf_rst", perf_branches, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
